calc_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one calculator core (control unit plus datapath) between two requesters. It sits between the requesters and the core. It latches the winning requester's function code and operands, pulses the core's go input, and waits for the core's done. It then returns the result to the winner, tagged with that requester's id.

---
 rtl/calc_arbiter.sv | 162 ++++++++++++++++
 tb/tb_calc_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_arbiter.sv
// Two-port round-robin arbiter/sequencer sharing one calculator core between two requesters.
// Optional WAIT-state watchdog compiled in with `define CALC_ARB_TIMEOUT_EN.
module calc_arbiter #(
  parameter int W       = 4,
  parameter int RW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [2:0]    f0,
  input  logic [2:0]    f1,
  input  logic [W-1:0]  a0,
  input  logic [W-1:0]  a1,
  input  logic [W-1:0]  b0,
  input  logic [W-1:0]  b1,
  output logic          ack0,
  output logic          ack1,
  output logic [RW-1:0] res,
  output logic          res_id,
  output logic          res_valid,
  output logic          res_err,
  output logic          busy,
  output logic          core_go,
  output logic [2:0]    core_f,
  output logic [W-1:0]  core_a,
  output logic [W-1:0]  core_b,
  input  logic          core_done,
  input  logic [RW-1:0] core_result,
  output logic          core_abort,
  output logic [2:0]    state_dbg
);

  // Handshake: a requester raises req with stable f/a/b and holds it until its
  // one-cycle ack; it drops req on the edge that ends the ack cycle. core_go is a
  // one-cycle start pulse; core_done is a level sampled only in WAIT.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    GO    = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t state;
  logic   last_grant;
  logic   sel;
  logic   req_win;

  assign state_dbg = state;

  // On a tie the requester that was not served last wins.
  always_comb begin
    req_win = req1;
    if (req0 && req1) req_win = ~last_grant;
  end

`ifdef CALC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_nxt;

  assign cnt_nxt = wait_cnt + CW'(1);
`else
  logic unused_timeout;

  // TIMEOUT is only consumed by the watchdog build.
  assign unused_timeout = (TIMEOUT > 0);
  assign res_err        = 1'b0;
  assign core_abort     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      busy       <= 1'b0;
      core_go    <= 1'b0;
      core_f     <= '0;
      core_a     <= '0;
      core_b     <= '0;
      res        <= '0;
      res_id     <= 1'b0;
      res_valid  <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
`ifdef CALC_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      res_err    <= 1'b0;
      core_abort <= 1'b0;
`endif
    end else begin
      core_go    <= 1'b0;
      res_valid  <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
`ifdef CALC_ARB_TIMEOUT_EN
      res_err    <= 1'b0;
      core_abort <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel   <= req_win;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          core_f     <= sel ? f1 : f0;
          core_a     <= sel ? a1 : a0;
          core_b     <= sel ? b1 : b0;
          res_id     <= sel;
          last_grant <= sel;
          core_go    <= 1'b1;
          state      <= GO;
        end
        GO: begin
`ifdef CALC_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // core_done beats a simultaneous watchdog expiry.
          if (core_done) begin
            res       <= core_result;
            res_valid <= 1'b1;
            ack0      <= ~res_id;
            ack1      <= res_id;
            state     <= RESP;
          end
`ifdef CALC_ARB_TIMEOUT_EN
          else if (cnt_nxt == CW'(TIMEOUT)) begin
            res        <= '0;
            res_valid  <= 1'b1;
            res_err    <= 1'b1;
            core_abort <= 1'b1;
            ack0       <= ~res_id;
            ack1       <= res_id;
            state      <= RESP;
          end else begin
            wait_cnt <= cnt_nxt;
          end
`endif
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: transaction-timed reference model, bench-side core model, random requesters.
// Directed scenarios plus a randomized run; build with CALC_ARB_TIMEOUT_EN to cover the watchdog.
module tb_calc_arbiter;
  localparam int W  = 4;
  localparam int RW = 8;
`ifdef CALC_ARB_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 64;
`endif
  localparam int NEVER = 1 << 30;

  logic          clk;
  logic          rst;
  logic          req0, req1;
  logic [2:0]    f0, f1;
  logic [W-1:0]  a0, a1, b0, b1;
  logic          ack0, ack1;
  logic [RW-1:0] res;
  logic          res_id, res_valid, res_err, busy, core_go;
  logic [2:0]    core_f;
  logic [W-1:0]  core_a, core_b;
  logic          core_done;
  logic [RW-1:0] core_result;
  logic          core_abort;
  logic [2:0]    state_dbg;

  calc_arbiter #(.W(W), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .f0(f0), .f1(f1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1),
    .res(res), .res_id(res_id), .res_valid(res_valid), .res_err(res_err),
    .busy(busy), .core_go(core_go),
    .core_f(core_f), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_result(core_result), .core_abort(core_abort),
    .state_dbg(state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;

  // reference model: one operation in flight, timed from the cycle it was arbitrated
  bit            m_busy, m_id, m_last, m_err;
  int            m_start, m_go_at, m_resp_at;
  logic [2:0]    m_f;
  logic [W-1:0]  m_a, m_b;
  logic [RW-1:0] m_res;
  logic [2:0]    e_f;
  logic [W-1:0]  e_a, e_b;
  logic          e_id;
  logic [RW-1:0] e_res;
  logic [RW+1:0] exp_q[$];
  logic [RW+1:0] served_q[$];
  int            rv_n_q[$];
  int            last_go_n, req_n;

  // core model and requester drivers
  bit c_active, c_mute, spur_en;
  int c_done_at, lat_min, lat_max;
  bit pend[2], dropped[2], auto_en[2], force_req[2];
  logic [2:0]   force_f[2];
  logic [W-1:0] force_a[2], force_b[2];
  int gap[2], gap_max, early_pct, rst_cnt;

  function automatic logic [RW-1:0] core_fn(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [RW-1:0] x, y;
    x = RW'(a);
    y = RW'(b);
    case (f)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x * y;
      3'd3: return x & y;
      3'd4: return x | y;
      3'd5: return x ^ y;
      3'd6: return x << 1;
      default: return ~x;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_err = 0; m_resp_at = NEVER; m_go_at = NEVER; m_start = NEVER;
    e_f = '0; e_a = '0; e_b = '0; e_id = 1'b0; e_res = '0;
    exp_q.delete();
    c_active = 0; core_done = 1'b0;
    dropped[0] = 0; dropped[1] = 0;
  endtask

  task automatic compare();
    bit rv;
    rv = m_busy && (n == m_resp_at);
    chk("busy", busy, m_busy);
    chk("core_go", core_go, m_busy && (n == m_go_at));
    chk("res_valid", res_valid, rv);
    chk("ack0", ack0, rv && !m_id);
    chk("ack1", ack1, rv && m_id);
    chk("res_err", res_err, rv && m_err);
    chk("core_abort", core_abort, rv && m_err);
    chk("res", res, e_res);
    chk("res_id", res_id, e_id);
    chk("core_f", core_f, e_f);
    chk("core_a", core_a, e_a);
    chk("core_b", core_b, e_b);
    if (core_go === 1'b1) last_go_n = n;
    if (res_valid === 1'b1) begin
      served_q.push_back({res_err, res_id, res});
      rv_n_q.push_back(n);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected cycle %0d: got result %0h with nothing expected", n, {res_err, res_id, res});
      end else begin
        chk("sb_result", {res_err, res_id, res}, exp_q.pop_front());
      end
    end
  endtask

  task automatic load_req(input int i, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[i] = 1; dropped[i] = 0; req_n = n;
    if (i == 0) begin f0 = f; a0 = a; b0 = b; end
    else        begin f1 = f; a1 = a; b1 = b; end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 2; i++) begin
      bit ak;
      ak = (i == 0) ? (ack0 === 1'b1) : (ack1 === 1'b1);
      if (ak) begin
        pend[i] = 0; dropped[i] = 0; gap[i] = $urandom_range(gap_max, 0);
      end else if (!pend[i] && force_req[i]) begin
        force_req[i] = 0;
        load_req(i, force_f[i], force_a[i], force_b[i]);
      end else if (!pend[i] && auto_en[i]) begin
        if (gap[i] == 0)
          load_req(i, 3'($urandom_range(7, 0)), W'($urandom_range((1 << W) - 1, 0)),
                   W'($urandom_range((1 << W) - 1, 0)));
        else gap[i]--;
      end else if (pend[i] && !dropped[i] && m_busy && (m_id == i) && (n == m_start + 1) &&
                   ($urandom_range(99, 0) < early_pct)) begin
        dropped[i] = 1;
      end
    end
    req0 = pend[0] & ~dropped[0];
    req1 = pend[1] & ~dropped[1];
  endtask

  task automatic drive_core();
    if (core_go === 1'b1 && !rst) begin
      c_active = 1;
      c_done_at = n + int'($urandom_range(lat_max, lat_min));
    end
    core_done = 1'b0;
    core_result = RW'($urandom);
    if (c_active && !c_mute && n == c_done_at) begin
      core_done = 1'b1;
      core_result = core_fn(core_f, core_a, core_b);
      c_active = 0;
      if (m_busy) begin
        m_res = core_fn(m_f, m_a, m_b);
        m_resp_at = n + 1;
        m_err = 0;
        exp_q.push_back({1'b0, m_id, m_res});
      end
    end else if (!c_active && spur_en && $urandom_range(3, 0) == 0) begin
      core_done = 1'b1;
    end
  endtask

  task automatic model_update();
    if (m_busy && n == m_start + 1) begin
      e_f = m_f; e_a = m_a; e_b = m_b; e_id = m_id;
    end
`ifdef CALC_ARB_TIMEOUT_EN
    if (m_busy && n == m_go_at && c_mute) begin
      m_resp_at = n + TIMEOUT + 1;
      m_err = 1;
      m_res = '0;
      exp_q.push_back({1'b1, m_id, {RW{1'b0}}});
    end
`endif
    if (m_busy && n == m_resp_at - 1) e_res = m_res;
    if (!m_busy && !rst && (req0 || req1)) begin
      m_id = (req0 && req1) ? ~m_last : req1;
      m_last = m_id;
      m_busy = 1;
      m_start = n; m_go_at = n + 2; m_resp_at = NEVER; m_err = 0;
      m_f = m_id ? f1 : f0;
      m_a = m_id ? a1 : a0;
      m_b = m_id ? b1 : b0;
    end else if (m_busy && n == m_resp_at) begin
      m_busy = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    n++;
    compare();
    if (rst_cnt > 0) begin
      rst = 1'b1;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_core_go", core_go, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_ack0", ack0, 1'b0);
      chk("rst_ack1", ack1, 1'b0);
      chk("rst_res", res, '0);
      model_reset();
      rst_cnt--;
    end else begin
      rst = 1'b0;
    end
    drive_reqs();
    drive_core();
    model_update();
  endtask

  task automatic run_until_served(input int k, input int bound, input string name);
    int target, c;
    target = served_q.size() + k;
    c = 0;
    while (served_q.size() < target && c < bound) begin
      step();
      c++;
    end
    checks++;
    if (served_q.size() < target) begin
      errors++;
      $display("FAIL %s: %0d of %0d results within %0d cycles", name, served_q.size() + k - target, k, bound);
    end
  endtask

  task automatic run_until_idle(input int bound);
    int c;
    c = 0;
    while ((m_busy || pend[0] || pend[1]) && c < bound) begin
      step();
      c++;
    end
    checks++;
    if (m_busy || pend[0] || pend[1]) begin
      errors++;
      $display("FAIL drain: still busy after %0d cycles", bound);
    end
  endtask

  task automatic set_force(input int i, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    force_req[i] = 1; force_f[i] = f; force_a[i] = a; force_b[i] = b;
  endtask

  initial begin
    int base;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    f0 = '0; f1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    core_done = 1'b0; core_result = '0;
    c_mute = 0; spur_en = 0; lat_min = 3; lat_max = 3; gap_max = 0; early_pct = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; dropped[i] = 0; auto_en[i] = 0; force_req[i] = 0; gap[i] = 0;
    end
    model_reset();
    #2 rst = 1'b1;
    rst_cnt = 2;
    repeat (4) step();
    chk("reset_busy", busy, 1'b0);
    chk("reset_res_id", res_id, 1'b0);

    // single request, core answers three cycles after go
    set_force(0, 3'd0, 4'd5, 4'd3);
    run_until_served(1, 30, "single");
    chk("single_result", served_q[served_q.size() - 1], {1'b0, 1'b0, 8'd8});
    chk("single_go_delay", last_go_n - req_n, 2);
    chk("single_latency", rv_n_q[rv_n_q.size() - 1] - last_go_n, 4);
    repeat (3) step();

    // simultaneous requests straight after reset
    rst_cnt = 2;
    set_force(0, 3'd1, 4'd9, 4'd2);
    set_force(1, 3'd5, 4'd12, 4'd10);
    base = served_q.size();
    run_until_served(2, 40, "simultaneous");
    chk("sim_first", served_q[base], {1'b0, 1'b0, 8'd7});
    chk("sim_second", served_q[base + 1], {1'b0, 1'b1, 8'd6});
    chk("sim_gap", rv_n_q[base + 1] - rv_n_q[base], 7);
    repeat (2) step();

    // fairness with both requesters held continuously
    lat_min = 1; lat_max = 4; gap_max = 0;
    gap[0] = 0; gap[1] = 0;
    auto_en[0] = 1; auto_en[1] = 1;
    base = served_q.size();
    run_until_served(4, 80, "fairness");
    auto_en[0] = 0; auto_en[1] = 0;
    for (int k = 0; k < 4; k++) chk("fair_id", served_q[base + k][RW], k % 2);
    run_until_idle(60);

    // reset while waiting on the core; requester 1 keeps holding req
    set_force(1, 3'd3, 4'd12, 4'd10);
    c_mute = 1;
    begin
      int c;
      c = 0;
      while (!(m_busy && n >= m_go_at + 2) && c < 20) begin step(); c++; end
      chk("midwait_reached", m_busy && (n >= m_go_at + 2), 1'b1);
    end
    rst_cnt = 2;
    c_mute = 0;
    run_until_served(1, 30, "after_reset");
    chk("after_reset_result", served_q[served_q.size() - 1], {1'b0, 1'b1, 8'd8});
    repeat (2) step();

    // requester drops req the cycle after grant
    early_pct = 100;
    set_force(1, 3'd2, 4'd7, 4'd6);
    run_until_served(1, 30, "early_drop");
    chk("early_drop_result", served_q[served_q.size() - 1], {1'b0, 1'b1, 8'd42});
    early_pct = 0;
    repeat (2) step();

    // core never answers
    set_force(0, 3'd0, 4'd1, 4'd1);
    c_mute = 1;
`ifdef CALC_ARB_TIMEOUT_EN
    run_until_served(1, 40, "timeout");
    chk("timeout_result", served_q[served_q.size() - 1], {1'b1, 1'b0, 8'd0});
    chk("timeout_latency", rv_n_q[rv_n_q.size() - 1] - last_go_n, TIMEOUT + 1);
    c_mute = 0;
`else
    repeat (40) step();
    chk("stuck_busy", busy, 1'b1);
    rst_cnt = 2;
    c_mute = 0;
    run_until_served(1, 30, "stuck_recover");
    chk("stuck_recover_result", served_q[served_q.size() - 1], {1'b0, 1'b0, 8'd2});
`endif
    repeat (2) step();

    // randomized traffic
    lat_min = 1; lat_max = 5; gap_max = 3; early_pct = 25; spur_en = 1;
    auto_en[0] = 1; auto_en[1] = 1;
    repeat (1500) begin
      if ($urandom_range(199, 0) == 0) rst_cnt = 1;
      step();
    end
    auto_en[0] = 0; auto_en[1] = 0;
    run_until_idle(100);
    repeat (3) step();
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
